// File: rtl/axis_rr_arbiter_if.sv
// AXI-Stream bundle between N_SRC sources and the single arbitrated master port.
// The master modport is the arbiter's view; slave is the environment's view.
interface axis_rr_arbiter_if #(
  parameter int N_SRC = 4
) ();
  logic [N_SRC-1:0]   s_tvalid;
  logic [N_SRC-1:0]   s_tlast;
  logic [N_SRC-1:0]   s_tready;
  logic [N_SRC*8-1:0] s_tdata;
  logic [N_SRC*4-1:0] s_tdest;
  logic [N_SRC*4-1:0] s_tuser;
  logic [N_SRC*2-1:0] s_tid;

  logic       m_tvalid;
  logic       m_tlast;
  logic       m_tready;
  logic [7:0] m_tdata;
  logic [3:0] m_tdest;
  logic [3:0] m_tuser;
  logic [1:0] m_tid;

  modport master (
    input  s_tvalid, s_tlast, s_tdata, s_tdest, s_tuser, s_tid, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tdata, m_tdest, m_tuser, m_tid
  );

  modport slave (
    output s_tvalid, s_tlast, s_tdata, s_tdest, s_tuser, s_tid, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_tdata, m_tdest, m_tuser, m_tid
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: up to 4 AXIS sources onto one master port.
// A grant is held for a whole packet; IDLE always inserts one bubble between packets.
module axis_rr_arbiter #(
  parameter int N_SRC       = 4,
  parameter int ID_OVERRIDE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src_en,
  axis_rr_arbiter_if.master   bus,
  output logic [1:0]          grant_idx,
  output logic                busy,
  output logic [15:0]         pkt_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [1:0] LAST_IDX = 2'(N_SRC - 1);

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  // Source vectors widened to four lanes so a 2-bit index is always in range.
  logic [3:0]  req_pad, valid_pad, last_pad, ready_pad;
  logic [31:0] data_pad;
  logic [15:0] dest_pad, user_pad;
  logic [7:0]  tid_pad;

  always_comb begin
    req_pad   = '0;
    valid_pad = '0;
    last_pad  = '0;
    data_pad  = '0;
    dest_pad  = '0;
    user_pad  = '0;
    tid_pad   = '0;
    req_pad[N_SRC-1:0]     = bus.s_tvalid & src_en;
    valid_pad[N_SRC-1:0]   = bus.s_tvalid;
    last_pad[N_SRC-1:0]    = bus.s_tlast;
    data_pad[N_SRC*8-1:0]  = bus.s_tdata;
    dest_pad[N_SRC*4-1:0]  = bus.s_tdest;
    user_pad[N_SRC*4-1:0]  = bus.s_tuser;
    tid_pad[N_SRC*2-1:0]   = bus.s_tid;
  end

  // First requesting source at or above rr_ptr, wrapping at N_SRC.
  logic [1:0] pick;
  logic       found;

  always_comb begin
    logic [1:0] idx;
    pick  = rr_ptr_q;
    found = 1'b0;
    idx   = rr_ptr_q;
    for (int k = 0; k < N_SRC; k++) begin
      if (!found && req_pad[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    end
  end

  // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    ready_pad = '0;

    bus.m_tvalid = 1'b0;
    bus.m_tlast  = 1'b0;
    bus.m_tdata  = data_pad[{grant_q, 3'b000} +: 8];
    bus.m_tdest  = dest_pad[{grant_q, 2'b00} +: 4];
    bus.m_tuser  = user_pad[{grant_q, 2'b00} +: 4];
    bus.m_tid    = (ID_OVERRIDE != 0) ? grant_q : tid_pad[{grant_q, 1'b0} +: 2];

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bus.m_tvalid       = valid_pad[grant_q];
        bus.m_tlast        = last_pad[grant_q];
        ready_pad[grant_q] = bus.m_tready;
        if (valid_pad[grant_q] && bus.m_tready && last_pad[grant_q]) begin
          rr_ptr_d  = (grant_q == LAST_IDX) ? 2'd0 : grant_q + 2'd1;
          pkt_cnt_d = pkt_cnt_q + 16'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    bus.s_tready = ready_pad[N_SRC-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == GRANT);
  assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: doc/axis_rr_arbiter.md
AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

Interface
REQ-001 SHALL have parameter N_SRC, default 4, number of AXIS source ports (2..4; tid width 2 bits holds index).
REQ-002 SHALL have parameter ID_OVERRIDE, default 1, 1 = m_tid carries granted source index, 0 = pass s_tid through.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 src_en  input  N_SRC  per-source arbitration enable, sampled only in IDLE.
REQ-007 s_tvalid/s_tlast  input  N_SRC each  source valid / last-beat flags.
REQ-008 s_tdata  input  N_SRC*8  source data, source i at bits [8i+7:8i].
REQ-009 s_tdest/s_tuser  input  N_SRC*4 each  source sideband, 4 bits per source.
REQ-010 s_tid  input  N_SRC*2  source id, 2 bits per source.
REQ-011 s_tready  output  N_SRC  per-source ready.
REQ-012 m_tvalid/m_tlast  output  1 each  master valid / last.
REQ-013 m_tdata 8, m_tdest 4, m_tid 2, m_tuser 4  output  master payload and sideband.
REQ-014 m_tready  input  1  downstream ready.
REQ-015 grant_idx  output  2  index of current/last granted source.
REQ-016 busy  output  1  high while in GRANT state.
REQ-017 pkt_cnt  output  16  count of completed packets, wraps 0xFFFF->0.

Function
REQ-018 FSM states IDLE, GRANT; SHALL change state only on clk rising edge.
REQ-019 IDLE: all s_tready=0, m_tvalid=0, m_tlast=0, busy=0.
REQ-020 IDLE: req = s_tvalid & src_en; if req!=0, pick first set bit searching from rr_ptr upward, wrapping at N_SRC; register grant_idx, enter GRANT.
REQ-021 Arbitration latency SHALL be 1 cycle: first beat on master no earlier than cycle after request seen in IDLE.
REQ-022 GRANT: m_tvalid/m_tdata/m_tdest/m_tuser/m_tlast combinationally equal source grant_idx; s_tready[grant_idx]=m_tready; all other s_tready=0.
REQ-023 m_tid SHALL equal grant_idx when ID_OVERRIDE=1, else s_tid of granted source.
REQ-024 Grant SHALL be held for the whole packet; no switch before handshake (m_tvalid & m_tready & m_tlast).
REQ-025 On last-beat handshake: rr_ptr <= (grant_idx+1) mod N_SRC, pkt_cnt += 1, next state IDLE; one-cycle bubble between packets is required.
REQ-026 src_en change during GRANT SHALL not affect the current packet.
REQ-027 Granted source dropping s_tvalid mid-packet: m_tvalid follows low, grant held, no timeout.
REQ-028 Single-beat packet (tlast on first beat) SHALL complete in one GRANT cycle if m_tready=1.
REQ-029 m_tready low SHALL stall with payload stable as presented by source; no beat lost or duplicated.
REQ-030 Non-granted sources SHALL never see s_tready=1.

Reset
REQ-031 rst=1: state IDLE, rr_ptr=0, grant_idx=0, pkt_cnt=0, busy=0, all s_tready=0, m_tvalid=0.
REQ-032 rst mid-packet SHALL abort the grant on the next edge; partial packet not counted; after release arbitration restarts from source 0.

Verification
REQ-033 Sources 0 and 2 each hold a 3-beat packet, src_en=0xF -> source 0 granted first (bytes on m_tdata, m_tid=0), 1 bubble, then source 2 (m_tid=2), pkt_cnt=2.
REQ-034 All 4 sources continuously valid with 1-beat packets -> grant order 0,1,2,3,0,...; each packet 2 cycles (GRANT + IDLE); pkt_cnt increments every 2 cycles.
REQ-035 Source 1 sends 4 beats 0xA1..0xA4, m_tready toggles 1,0,1,0... -> m_tdata sequence A1..A4 exactly once each, s_tready[1]=m_tready, others 0.
REQ-036 src_en=0b1101, only source 1 valid -> never granted, m_tvalid=0; set src_en[1]=1 -> grant_idx=1 next cycle.
REQ-037 rst asserted after beat 2 of 5 on source 3 -> next cycle s_tready=0, busy=0, pkt_cnt=0; after release, sources 3 and 0 valid -> source 0 granted first.
REQ-038 ID_OVERRIDE=0, source 2 s_tid=1 -> m_tid=1, grant_idx=2.
